// File: rtl/fpu_seq_pkg.sv
// Shared FPU sequencer types: phase states, operation codes, op classes and
// the datapath latency defaults used to size the BUSY phase.
package fpu_seq_pkg;

  localparam int FPU_32_F    = 23;
  localparam int FPU_GRS     = 3;
  localparam int FPU_ADD_LAT = 1;
  localparam int FPU_MUL_LAT = 3;
  localparam int FPU_DIV_LAT = FPU_32_F + FPU_GRS + 1;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_BUSY  = 3'd1,
    S_NORM  = 3'd2,
    S_ROUND = 3'd3,
    S_WAIT  = 3'd4
  } state_t;

  typedef enum logic [4:0] {
    OP_ADD        = 5'd0,
    OP_SUB        = 5'd1,
    OP_MUL        = 5'd2,
    OP_DIV        = 5'd3,
    OP_SLL        = 5'd4,
    OP_SRL        = 5'd5,
    OP_AND        = 5'd6,
    OP_OR         = 5'd7,
    OP_XOR        = 5'd8,
    OP_NOT        = 5'd9,
    OP_CONV_INT   = 5'd10,
    OP_CONV_FLOAT = 5'd11
  } op_t;

  typedef enum logic [2:0] {
    CLS_ARITH   = 3'd0,
    CLS_LOGIC   = 3'd1,
    CLS_CVT_I   = 3'd2,
    CLS_CVT_F   = 3'd3,
    CLS_ILLEGAL = 3'd4
  } op_class_t;

  // Codes outside the Operation enum (12..31) fall to ILLEGAL.
  function automatic op_class_t op_class(input logic [4:0] op);
    op_class_t cls;
    case (op)
      OP_ADD, OP_SUB, OP_MUL, OP_DIV:                   cls = CLS_ARITH;
      OP_SLL, OP_SRL, OP_AND, OP_OR, OP_XOR, OP_NOT:    cls = CLS_LOGIC;
      OP_CONV_INT:                                      cls = CLS_CVT_I;
      OP_CONV_FLOAT:                                    cls = CLS_CVT_F;
      default:                                          cls = CLS_ILLEGAL;
    endcase
    return cls;
  endfunction

endpackage

// File: rtl/fpu_op_decode.sv
// Combinational op decoder: maps an op code to its class and BUSY-phase length.
module fpu_op_decode
  import fpu_seq_pkg::*;
#(
  parameter int CNT_W   = 6,
  parameter int ADD_LAT = FPU_ADD_LAT,
  parameter int MUL_LAT = FPU_MUL_LAT,
  parameter int DIV_LAT = FPU_DIV_LAT
) (
  input  logic [4:0]       op,
  output op_class_t        cls,
  output logic [CNT_W-1:0] lat
);

  // Non-arithmetic classes spend exactly one cycle in BUSY.
  always_comb begin
    cls = op_class(op);
    case (op)
      OP_ADD, OP_SUB: lat = CNT_W'(ADD_LAT);
      OP_MUL:         lat = CNT_W'(MUL_LAT);
      OP_DIV:         lat = CNT_W'(DIV_LAT);
      default:        lat = CNT_W'(1);
    endcase
  end

endmodule

// File: rtl/fpu_seq.sv
// Single-issue FPU sequencer: accepts one op, steps it through BUSY/NORM/ROUND,
// strobes the datapath and holds the result on a valid/ready response channel.
module fpu_seq
  import fpu_seq_pkg::*;
#(
  parameter int TAG_W   = 4,
  parameter int ADD_LAT = FPU_ADD_LAT,
  parameter int MUL_LAT = FPU_MUL_LAT,
  parameter int DIV_LAT = FPU_DIV_LAT,
  parameter int CNT_W   = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [4:0]       req_op,
  input  logic [TAG_W-1:0] req_tag,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [TAG_W-1:0] rsp_tag,
  output logic             rsp_illegal,
  output logic             dp_start,
  output logic [4:0]       dp_op,
  output logic             dp_norm_en,
  output logic             dp_round_en,
  output logic [2:0]       state_o,
  output logic             busy
);

  state_t           state_r, state_n;
  logic [CNT_W-1:0] cnt_r, cnt_n;
  logic [4:0]       op_r, op_n;
  logic [TAG_W-1:0] tag_r, tag_n;
  op_class_t        cls_r, cls_n;
  logic             illegal_r, illegal_n;
  logic             dp_start_r, dp_start_n;
  logic             norm_en_r, round_en_r, rsp_valid_r, busy_r;
  op_class_t        dec_cls_s;
  logic [CNT_W-1:0] dec_lat_s;
  logic             accept_s;

  fpu_op_decode #(
    .CNT_W  (CNT_W),
    .ADD_LAT(ADD_LAT),
    .MUL_LAT(MUL_LAT),
    .DIV_LAT(DIV_LAT)
  ) u_decode (
    .op (req_op),
    .cls(dec_cls_s),
    .lat(dec_lat_s)
  );

  // Combinational on rsp_ready so a new op can issue in the handshake cycle.
  assign req_ready = !rst && !flush &&
                     ((state_r == S_IDLE) || ((state_r == S_WAIT) && rsp_ready));
  assign accept_s  = req_valid && req_ready;

  // Next-state, counter and latched-operand logic.
  always_comb begin
    state_n    = state_r;
    cnt_n      = cnt_r;
    op_n       = op_r;
    tag_n      = tag_r;
    cls_n      = cls_r;
    illegal_n  = illegal_r;
    dp_start_n = 1'b0;
    if (flush) begin
      state_n = S_IDLE;
      cnt_n   = {CNT_W{1'b0}};
    end else if (accept_s) begin
      op_n  = req_op;
      tag_n = req_tag;
      cls_n = dec_cls_s;
      cnt_n = dec_lat_s - CNT_W'(1);
      if (dec_cls_s == CLS_ILLEGAL) begin
        state_n   = S_WAIT;
        illegal_n = 1'b1;
      end else begin
        state_n    = S_BUSY;
        illegal_n  = 1'b0;
        dp_start_n = 1'b1;
      end
    end else begin
      case (state_r)
        S_IDLE: state_n = S_IDLE;
        S_BUSY: begin
          if (cnt_r == {CNT_W{1'b0}}) begin
            case (cls_r)
              CLS_ARITH, CLS_CVT_F: state_n = S_NORM;
              CLS_CVT_I:            state_n = S_ROUND;
              default:              state_n = S_WAIT;
            endcase
          end else begin
            cnt_n = cnt_r - CNT_W'(1);
          end
        end
        S_NORM:  state_n = S_ROUND;
        S_ROUND: state_n = S_WAIT;
        S_WAIT: begin
          if (rsp_ready) begin
            state_n = S_IDLE;
          end else begin
            state_n = S_WAIT;
          end
        end
        default: state_n = S_IDLE;
      endcase
    end
  end

  // State, operand and output registers; strobes are decoded from the next state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r     <= S_IDLE;
      cnt_r       <= {CNT_W{1'b0}};
      op_r        <= 5'd0;
      tag_r       <= {TAG_W{1'b0}};
      cls_r       <= CLS_ARITH;
      illegal_r   <= 1'b0;
      dp_start_r  <= 1'b0;
      norm_en_r   <= 1'b0;
      round_en_r  <= 1'b0;
      rsp_valid_r <= 1'b0;
      busy_r      <= 1'b0;
    end else begin
      state_r     <= state_n;
      cnt_r       <= cnt_n;
      op_r        <= op_n;
      tag_r       <= tag_n;
      cls_r       <= cls_n;
      illegal_r   <= illegal_n;
      dp_start_r  <= dp_start_n;
      norm_en_r   <= (state_n == S_NORM);
      round_en_r  <= (state_n == S_ROUND);
      rsp_valid_r <= (state_n == S_WAIT);
      busy_r      <= (state_n != S_IDLE);
    end
  end

  assign rsp_valid   = rsp_valid_r;
  assign rsp_tag     = tag_r;
  assign rsp_illegal = illegal_r;
  assign dp_start    = dp_start_r;
  assign dp_op       = op_r;
  assign dp_norm_en  = norm_en_r;
  assign dp_round_en = round_en_r;
  assign state_o     = state_r;
  assign busy        = busy_r;

endmodule

// File: tb/tb_fpu_seq.sv
// Self-checking bench for fpu_seq: vector table, directed corner sequences and
// a randomized run against a transaction-timeline reference model.
module tb_fpu_seq;

  logic       clk = 1'b0;
  logic       rst, flush, req_valid, rsp_ready;
  logic [4:0] req_op;
  logic [3:0] req_tag;
  logic       req_ready, rsp_valid, rsp_illegal, dp_start, dp_norm_en, dp_round_en, busy;
  logic [3:0] rsp_tag;
  logic [4:0] dp_op;
  logic [2:0] state_o;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [4:0] op;
    logic [3:0] tag;
    int         hold;
    int         lat;
    int         n_start;
    int         n_norm;
    int         n_round;
    logic       ill;
  } vec_t;

  vec_t vecs[12];

  always #5 clk = ~clk;

  fpu_seq dut (
    .clk        (clk),
    .rst        (rst),
    .flush      (flush),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_op     (req_op),
    .req_tag    (req_tag),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_tag    (rsp_tag),
    .rsp_illegal(rsp_illegal),
    .dp_start   (dp_start),
    .dp_op      (dp_op),
    .dp_norm_en (dp_norm_en),
    .dp_round_en(dp_round_en),
    .state_o    (state_o),
    .busy       (busy)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Timeline of one op, derived from the latency table: rsp at L, strobes at offsets.
  function automatic void op_info(input logic [4:0] op, output int L, output int noff,
                                  output int roff, output bit ill);
    int lat;
    ill  = 1'b0;
    noff = -1;
    roff = -1;
    if (op <= 5'd3) begin
      lat  = (op == 5'd3) ? 27 : (op == 5'd2) ? 3 : 1;
      L    = lat + 3;
      noff = lat + 1;
      roff = lat + 2;
    end else if (op <= 5'd9) begin
      L = 2;
    end else if (op == 5'd10) begin
      L = 3; roff = 2;
    end else if (op == 5'd11) begin
      L = 4; noff = 2; roff = 3;
    end else begin
      L = 1; ill = 1'b1;
    end
  endfunction

  task automatic run_vec(input vec_t v, input int idx);
    int lat = 1, ns = 0, nn = 0, nr = 0, nrdy = 0;
    req_valid = 1'b1; req_op = v.op; req_tag = v.tag; rsp_ready = 1'b0;
    #1 chk($sformatf("v%0d_accept_ready", idx), req_ready, 1);
    tick();
    req_valid = 1'b0; req_op = ~v.op; req_tag = ~v.tag;
    while (rsp_valid !== 1'b1 && lat < 60) begin
      ns += int'(dp_start); nn += int'(dp_norm_en); nr += int'(dp_round_en);
      nrdy += int'(req_ready);
      chk($sformatf("v%0d_dp_op", idx), dp_op, v.op);
      tick();
      lat++;
    end
    chk($sformatf("v%0d_latency", idx), lat, v.lat);
    chk($sformatf("v%0d_starts", idx), ns, v.n_start);
    chk($sformatf("v%0d_norms", idx), nn, v.n_norm);
    chk($sformatf("v%0d_rounds", idx), nr, v.n_round);
    chk($sformatf("v%0d_ready_busy", idx), nrdy, 0);
    chk($sformatf("v%0d_tag", idx), rsp_tag, v.tag);
    chk($sformatf("v%0d_illegal", idx), rsp_illegal, v.ill);
    chk($sformatf("v%0d_wait_strobes", idx), {dp_start, dp_norm_en, dp_round_en}, 0);
    chk($sformatf("v%0d_busy", idx), busy, 1);
    for (int i = 0; i < v.hold; i++) begin
      tick();
      chk($sformatf("v%0d_hold_valid", idx), rsp_valid, 1);
      chk($sformatf("v%0d_hold_tag", idx), rsp_tag, v.tag);
    end
    rsp_ready = 1'b1;
    #1 chk($sformatf("v%0d_ready_wait", idx), req_ready, 1);
    tick();
    rsp_ready = 1'b0;
    chk($sformatf("v%0d_done_valid", idx), rsp_valid, 0);
    chk($sformatf("v%0d_done_busy", idx), busy, 0);
    chk($sformatf("v%0d_done_state", idx), state_o, 0);
  endtask

  task automatic run_random(input int n_cycles);
    int   cyc = 0, acc = 0, k, L = 1, noff = -1, roff = -1;
    bit   inflight = 1'b0, m_ill = 1'b0, e_valid, e_ready;
    logic [4:0] m_op = 5'd0;
    logic [3:0] m_tag = 4'd0;
    for (int n = 0; n < n_cycles; n++) begin
      k = cyc - acc;
      e_valid = inflight && (k >= L);
      chk("r_valid", rsp_valid, e_valid);
      chk("r_busy", busy, inflight);
      chk("r_start", dp_start, inflight && k == 1 && !m_ill);
      chk("r_norm", dp_norm_en, inflight && k == noff);
      chk("r_round", dp_round_en, inflight && k == roff);
      if (inflight) chk("r_dp_op", dp_op, m_op);
      else          chk("r_idle_state", state_o, 0);
      if (e_valid) begin
        chk("r_tag", rsp_tag, m_tag);
        chk("r_illegal", rsp_illegal, m_ill);
      end
      req_valid = 1'($urandom_range(0, 1));
      req_op    = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(12, 31))
                                              : 5'($urandom_range(0, 11));
      req_tag   = 4'($urandom_range(0, 15));
      rsp_ready = ($urandom_range(0, 2) != 0);
      flush     = ($urandom_range(0, 39) == 0);
      #1;
      e_ready = !flush && (!inflight || (e_valid && rsp_ready));
      chk("r_req_ready", req_ready, e_ready);
      if (flush) begin
        inflight = 1'b0;
      end else begin
        if (inflight && e_valid && rsp_ready) inflight = 1'b0;
        if (!inflight && req_valid && e_ready) begin
          inflight = 1'b1;
          acc      = cyc;
          m_op     = req_op;
          m_tag    = req_tag;
          op_info(req_op, L, noff, roff, m_ill);
        end
      end
      tick();
      cyc++;
    end
    req_valid = 1'b0; flush = 1'b0; rsp_ready = 1'b0;
  endtask

  initial begin
    int cnt;
    vecs[0]  = '{5'd0,  4'd3,  0, 4,  1, 1, 1, 1'b0};
    vecs[1]  = '{5'd1,  4'd7,  1, 4,  1, 1, 1, 1'b0};
    vecs[2]  = '{5'd2,  4'd9,  0, 6,  1, 1, 1, 1'b0};
    vecs[3]  = '{5'd3,  4'd5,  0, 30, 1, 1, 1, 1'b0};
    vecs[4]  = '{5'd8,  4'd1,  0, 2,  1, 0, 0, 1'b0};
    vecs[5]  = '{5'd9,  4'd14, 2, 2,  1, 0, 0, 1'b0};
    vecs[6]  = '{5'd4,  4'd2,  0, 2,  1, 0, 0, 1'b0};
    vecs[7]  = '{5'd10, 4'd6,  5, 3,  1, 0, 1, 1'b0};
    vecs[8]  = '{5'd11, 4'd11, 0, 4,  1, 1, 1, 1'b0};
    vecs[9]  = '{5'd20, 4'd12, 0, 1,  0, 0, 0, 1'b1};
    vecs[10] = '{5'd12, 4'd15, 1, 1,  0, 0, 0, 1'b1};
    vecs[11] = '{5'd31, 4'd0,  0, 1,  0, 0, 0, 1'b1};

    rst = 1'b1; flush = 1'b0; req_valid = 1'b1; req_op = 5'd0; req_tag = 4'd0; rsp_ready = 1'b0;
    #2;
    chk("rst_ready", req_ready, 0);
    chk("rst_outputs", {rsp_valid, rsp_illegal, dp_start, dp_norm_en, dp_round_en, busy}, 0);
    chk("rst_state", state_o, 0);
    tick();
    tick();
    rst = 1'b0; req_valid = 1'b0;
    #1 chk("idle_ready", req_ready, 1);
    tick();

    for (int i = 0; i < 12; i++) run_vec(vecs[i], i);

    // XOR then MUL issued in the XOR handshake cycle.
    req_valid = 1'b1; req_op = 5'd8; req_tag = 4'd1; rsp_ready = 1'b1;
    tick();
    chk("b2b_xor_start", dp_start, 1);
    req_op = 5'd2; req_tag = 4'd2;
    #1 chk("b2b_ready_busy", req_ready, 0);
    tick();
    chk("b2b_xor_valid", rsp_valid, 1);
    chk("b2b_xor_tag", rsp_tag, 1);
    #1 chk("b2b_ready_wait", req_ready, 1);
    tick();
    req_valid = 1'b0;
    chk("b2b_mul_start", dp_start, 1);
    chk("b2b_mul_op", dp_op, 2);
    chk("b2b_gap_valid", rsp_valid, 0);
    repeat (4) tick();
    chk("b2b_mul_early", rsp_valid, 0);
    tick();
    chk("b2b_mul_valid", rsp_valid, 1);
    chk("b2b_mul_tag", rsp_tag, 2);
    tick();
    rsp_ready = 1'b0;
    chk("b2b_idle", busy, 0);

    // MUL flushed two cycles after accept; flush also blocks a new request.
    req_valid = 1'b1; req_op = 5'd2; req_tag = 4'd4;
    tick();
    req_valid = 1'b0;
    tick();
    flush = 1'b1; req_valid = 1'b1; req_op = 5'd0;
    #1 chk("flush_ready", req_ready, 0);
    tick();
    flush = 1'b0; req_valid = 1'b0;
    chk("flush_busy", busy, 0);
    chk("flush_state", state_o, 0);
    chk("flush_strobes", {rsp_valid, dp_start, dp_norm_en, dp_round_en}, 0);
    cnt = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      cnt += int'(rsp_valid) + int'(dp_norm_en) + int'(dp_round_en);
    end
    chk("flush_quiet", cnt, 0);

    // Reset pulsed mid-DIV.
    req_valid = 1'b1; req_op = 5'd3; req_tag = 4'd5;
    tick();
    req_valid = 1'b0;
    repeat (10) tick();
    rst = 1'b1; req_valid = 1'b1;
    #1;
    chk("rstmid_outputs", {rsp_valid, rsp_illegal, dp_start, dp_norm_en, dp_round_en, busy}, 0);
    chk("rstmid_state", state_o, 0);
    chk("rstmid_tag_op", {rsp_tag, dp_op}, 0);
    chk("rstmid_ready", req_ready, 0);
    tick();
    chk("rstmid_ready_hold", req_ready, 0);
    rst = 1'b0; req_valid = 1'b0;
    cnt = 0;
    for (int i = 0; i < 35; i++) begin
      tick();
      cnt += int'(rsp_valid) + int'(busy);
    end
    chk("rstmid_lost", cnt, 0);

    run_random(3000);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fpu_seq.md
Name: fpu_seq

Overview:
- Single-issue sequencer for the FPU datapath.
- Accepts one operation at a time over a valid/ready request channel and walks it through the shared State phases: IDLE, BUSY, NORM, ROUND, WAIT.
- Drives the datapath's start, normalise and round strobes, then holds the result on a valid/ready response channel.
- Sits between the CPU issue stage and the FPU datapath.

Parameters:
- TAG_W, 4, width of the request/response tag.
- ADD_LAT, 1, BUSY cycles for ADD/SUB.
- MUL_LAT, 3, BUSY cycles for MUL.
- DIV_LAT, 27, BUSY cycles for DIV (FPU_32_F + FPU_GRS + 1).
- CNT_W, 6, BUSY down-counter width; must hold DIV_LAT-1.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- flush  in  1  synchronous abort of the in-flight op
- req_valid  in  1  request present
- req_ready  out  1  request accepted when high with req_valid
- req_op  in  5  Operation code
- req_tag  in  TAG_W  requester tag
- rsp_valid  out  1  result available
- rsp_ready  in  1  consumer takes result
- rsp_tag  out  TAG_W  tag of the completed op
- rsp_illegal  out  1  op code was outside the Operation enum
- dp_start  out  1  one-cycle datapath start pulse
- dp_op  out  5  latched op driven to the datapath
- dp_norm_en  out  1  normalise stage enable
- dp_round_en  out  1  rounding stage enable
- state_o  out  3  current State, for debug
- busy  out  1  state != IDLE

Behaviour:
- Reset (async, active-high): state=IDLE, counter=0, latched op/tag=0, illegal=0. All registered outputs are 0. req_ready=0 while rst is high.
- Op classes:
  - ARITH: ADD/SUB/MUL/DIV. Path BUSY->NORM->ROUND->WAIT.
  - LOGIC: SLL/SRL/AND/OR/XOR/NOT. BUSY for 1 cycle, then WAIT.
  - CVT_I: CONV_INT. BUSY 1 cycle, then ROUND, then WAIT.
  - CVT_F: CONV_FLOAT. BUSY 1 cycle, then NORM, then ROUND, then WAIT.
  - ILLEGAL: codes 12-31. Go directly to WAIT.
- Accept: req_ready = !rst && !flush && (state==IDLE || (state==WAIT && rsp_ready)). This is combinational on rsp_ready, which allows back-to-back issue.
- On accept: latch op and tag, load counter with lat(op)-1, next state BUSY. ILLEGAL instead goes to WAIT with illegal=1.
- BUSY:
  - dp_start=1 in the first BUSY cycle only.
  - dp_op holds the latched op from BUSY through WAIT.
  - If counter==0, advance per class; otherwise decrement.
- NORM: one cycle, dp_norm_en=1.
- ROUND: one cycle, dp_round_en=1.
- WAIT:
  - rsp_valid=1, rsp_tag and rsp_illegal stable.
  - If rsp_ready with no accept, next state IDLE.
  - If rsp_ready with an accept the same cycle, next state BUSY (or WAIT for an illegal op).
  - If !rsp_ready, hold; all outputs stay stable.
- Latency from accept edge to rsp_valid:
  - ARITH: lat + 3 (ADD=4, MUL=6, DIV=30).
  - LOGIC: 2.
  - CVT_I: 3.
  - CVT_F: 4.
  - ILLEGAL: 1.
- flush: from any state, next state IDLE and counter cleared. No response is produced and no dp_* strobes fire the next cycle. flush beats a simultaneous accept, because req_ready is low. flush in WAIT with rsp_ready high counts as a handshake (response consumed) and returns to IDLE.
- rst mid-op: immediate IDLE; the op is lost.
- req_op is sampled only on accept; changes while busy are ignored.

Decomposition:
- fpu_p additions:
  - typedef enum OpClass {ARITH, LOGIC, CVT_I, CVT_F, ILLEGAL}.
  - Latency defaults FPU_ADD_LAT, FPU_MUL_LAT, FPU_DIV_LAT.
  - Function op_class(Operation).
- Reuse the existing State and Operation enums.
- One combinational sub-module, fpu_op_decode: op code to {class, latency}. The FSM and counter stay in fpu_seq.

Test Plan:
- ADD, tag=3, rsp_ready=1 -> dp_start at accept+1; norm at +2; round at +3; rsp_valid at +4 with rsp_tag=3 for one cycle; then IDLE.
- DIV, tag=5 -> rsp_valid at accept+30; req_ready=0 throughout; busy=1 until handshake.
- XOR then MUL back-to-back, rsp_ready=1 -> XOR rsp at +2; MUL accepted in the same cycle as the XOR handshake; MUL rsp 6 cycles later with its own tag.
- CONV_INT with rsp_ready=0 for 5 cycles -> no dp_norm_en; dp_round_en at +2; rsp_valid held 6 cycles with stable tag; IDLE after rsp_ready.
- req_op=20 -> rsp_valid at +1 with rsp_illegal=1; no dp_start/norm/round.
- MUL with flush at accept+2, then rst pulsed mid-DIV -> IDLE next cycle with no rsp_valid; rst gives immediate IDLE with all outputs 0 and req_ready=0 while rst is high.
